dac_stream_tx: RTL
==================

# dac_stream_tx

Audio codec DAC serial transmitter, the playback-direction counterpart of the microphone capture path. It accepts signed N-bit PCM samples over a valid/ready handshake and buffers them in a small FIFO. It serialises them onto AUD_DACDAT in I2S format, using the codec-mastered AUD_BCLK and AUD_DACLRCK, all sampled in a single system clock domain. Each buffered sample is played on both left and right channels (mono playback), and the block flags underflow when the producer falls behind.

## Interface
- N, 16: sample width in bits, two's complement, MSB first on the wire.
- FIFO_DEPTH, 4: sample FIFO entries; must be a power of two and ≥2.
- clk  input  1  system clock (CLOCK_50 at top level); all state is on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sample_data  input  N  PCM sample to enqueue.
- sample_valid  input  1  sample_data is valid this cycle.
- sample_ready  output  1  FIFO can accept; combinational !full.
- bclk  input  1  codec bit clock (AUD_BCLK), asynchronous to clk.
- daclrck  input  1  codec DAC word clock (AUD_DACLRCK), asynchronous; low = left channel.
- dacdat  output  1  serial data to codec (AUD_DACDAT), registered.
- underflow  output  1  one-clk pulse when a left frame starts with the FIFO empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: dacdat=0, underflow=0, fifo_level=0, FIFO empty (so sample_ready=1); shift register, held sample, and bit counter = 0; state=WAIT_SYNC. Pushes are ignored while rst_n is low.
- Synchronisation: bclk and daclrck each pass through 2 flops. A bclk falling edge (bfall) is detected from the synced value and its registered copy. lrck_prev captures synced daclrck on every bfall.
- Boundary: a bfall where synced daclrck != lrck_prev. It is a left boundary if the new value is 0, otherwise a right boundary.
- FIFO push: sample_valid && sample_ready. Because sample_ready is low when full, a push is never accepted while full.
- Pop: occurs only on a left boundary, when the FIFO is not empty at that cycle; the popped value becomes the held sample.
  - If the FIFO is empty at a left boundary, underflow pulses and held = 0.
  - A push and a left-boundary pop in the same cycle with the FIFO empty counts as an underflow; there is no bypass, and the pushed sample stays queued.
- States:
  - WAIT_SYNC: dacdat=0; ignore everything except a left boundary, which performs the pop/underflow and goes to SHIFT. Right boundaries are ignored here.
  - SHIFT: entered at a boundary with shreg=word and cnt=N. dacdat is not changed on the boundary bfall (I2S one-BCLK delay slot). On each later bfall: dacdat<=shreg[N-1], shreg<<=1, cnt--. When cnt hits 0, go to PAD.
  - PAD: dacdat<=0 on the next bfall; hold 0 until a boundary.
  - Any boundary in SHIFT or PAD reloads shreg and cnt and re-enters SHIFT. A boundary arriving mid-word aborts the remaining bits.
- Words: a left boundary transmits the new held sample; a right boundary transmits the same held sample again.
- fifo_level = pushes − pops; it is unchanged on a simultaneous push+pop.
- Reset mid-operation: all state returns to reset values immediately; output resumes only after the next left boundary.

## Timing
- The 2-flop sync plus the edge register put bfall detection 3 clk after the pin falling edge. dacdat changes on the clk after detection.
- Requirement: bclk high and low times are each ≥6 clk periods, so dacdat is stable before the codec samples it on the rising edge.
- Latency: a sample pushed into an empty FIFO before a left boundary has its MSB on dacdat one BCLK after that daclrck fall, +4 clk.
- underflow and fifo_level update in the same cycle as the pop decision.
- Frame length: any number of BCLK per channel ≥ N+1. Shorter frames truncate the word's LSBs.

## Configuration
- DAC_TX_HOLD_LAST_EN
  - Defined: on underflow, the held sample keeps its previous value, so the last sample repeats. underflow still pulses.
  - Undefined: on underflow, held = 0, giving silence.

## Test plan
- N=16, 32 BCLK/channel, push 0xA5C3 before the first left boundary → dacdat = 1010010111000011 starting on the 2nd BCLK of left, same on right, 0 otherwise; fifo_level goes 1→0.
- No pushes after sync → dacdat=0 every frame; underflow pulses exactly once per daclrck fall, never on a rise.
- Hold sample_valid high with 5 distinct samples before any boundary → sample_ready falls after the 4th accept, fifo_level=4; ready returns the cycle after the next left-boundary pop; the samples play in order.
- Assert rst_n low during bit 7 of a word → dacdat=0 and fifo_level=0 immediately. After release, the first right boundary is ignored and output restarts at the next left boundary.
- Push 0x1234 only, run 2 frames → with DAC_TX_HOLD_LAST_EN, 0x1234 in both frames; without it, 0x1234 then 0x0000; underflow pulses at frame 2 in both builds.
- Swept bclk with high/low of 6 clk and 40 clk → bit-exact output for both.

Source files
------------

// File: rtl/dac_stream_tx_if.sv
// Sample stream handshake between a PCM producer and the DAC serial transmitter.
interface dac_stream_tx_if #(
  parameter int N = 16
) ();
  logic [N-1:0] sample_data;
  logic         sample_valid;
  logic         sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/dac_stream_tx.sv
// I2S mono DAC transmitter: FIFO-buffered PCM samples are serialised on both channels.
// Optional DAC_TX_HOLD_LAST_EN: repeat the last sample on underflow instead of silence.
module dac_stream_tx #(
  parameter int N          = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  dac_stream_tx_if.slave                smp_if,
  input  logic                          bclk,
  input  logic                          daclrck,
  output logic                          dacdat,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT     = 2'd1,
    PAD       = 2'd2
  } state_t;

  logic          r_bclk_s1, r_bclk_s2, r_bclk_d;
  logic          r_lrck_s1, r_lrck_s2, r_lrck_prev;
  logic [N-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic [N-1:0]  r_held;
  logic          r_underflow;
  state_t        r_state;
  logic [N-1:0]  r_shreg;
  logic [CW-1:0] r_cnt;
  logic          r_dacdat;

  logic          w_bfall, w_bnd, w_left;
  logic          w_full, w_empty, w_push, w_pop;
  logic [N-1:0]  w_held_nx, w_word;
  state_t        w_state_nx;
  logic [N-1:0]  w_shreg_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_dacdat_nx;

  assign w_bfall = r_bclk_d & ~r_bclk_s2;
  assign w_bnd   = w_bfall & (r_lrck_s2 != r_lrck_prev);
  assign w_left  = w_bnd & ~r_lrck_s2;

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = smp_if.sample_valid & ~w_full;
  assign w_pop   = w_left & ~w_empty;

  assign smp_if.sample_ready = ~w_full;
  assign dacdat              = r_dacdat;
  assign underflow           = r_underflow;
  assign fifo_level          = r_level;

  always_comb begin
    w_held_nx = r_held;
    if (w_left) begin
      if (!w_empty) w_held_nx = r_mem[r_rptr];
`ifdef DAC_TX_HOLD_LAST_EN
      else          w_held_nx = r_held;
`else
      else          w_held_nx = '0;
`endif
    end
  end

  // Right boundaries leave the held sample untouched, so both channels load the same word.
  assign w_word = w_held_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_d    <= 1'b0;
      r_lrck_s1   <= 1'b0;
      r_lrck_s2   <= 1'b0;
      r_lrck_prev <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_held      <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_bclk_s1   <= bclk;
      r_bclk_s2   <= r_bclk_s1;
      r_bclk_d    <= r_bclk_s2;
      r_lrck_s1   <= daclrck;
      r_lrck_s2   <= r_lrck_s1;
      if (w_bfall) r_lrck_prev <= r_lrck_s2;
      if (w_push)  r_wptr <= r_wptr + AW'(1);
      if (w_pop)   r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      r_held      <= w_held_nx;
      r_underflow <= w_left & w_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= smp_if.sample_data;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_shreg_nx  = r_shreg;
    w_cnt_nx    = r_cnt;
    w_dacdat_nx = r_dacdat;
    case (r_state)
      WAIT_SYNC: begin
        w_dacdat_nx = 1'b0;
        if (w_left) begin
          w_state_nx = SHIFT;
          w_shreg_nx = w_word;
          w_cnt_nx   = CW'(N);
        end
      end
      SHIFT: begin
        // The boundary bfall is the I2S delay slot: reload but leave dacdat alone.
        if (w_bnd) begin
          w_shreg_nx = w_word;
          w_cnt_nx   = CW'(N);
        end else if (w_bfall) begin
          w_dacdat_nx = r_shreg[N-1];
          w_shreg_nx  = {r_shreg[N-2:0], 1'b0};
          w_cnt_nx    = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_state_nx = PAD;
        end
      end
      PAD: begin
        if (w_bnd) begin
          w_state_nx = SHIFT;
          w_shreg_nx = w_word;
          w_cnt_nx   = CW'(N);
        end else if (w_bfall) begin
          w_dacdat_nx = 1'b0;
        end
      end
      default: w_state_nx = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= WAIT_SYNC;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_dacdat <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_shreg  <= w_shreg_nx;
      r_cnt    <= w_cnt_nx;
      r_dacdat <= w_dacdat_nx;
    end
  end

endmodule
